// File: rtl/rr_bus_arbiter4.sv
// Four-requester round-robin arbiter that drives the mux4 select code.
// Each owner holds the bus for a bounded time, and every ownership change passes through a one-cycle turnaround.
module rr_bus_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic [1:0] state;
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic [7:0] hold_cnt;
  logic       rel_norm;
  logic       rel_lim;

  // The search starts one past the last owner and wraps naturally in 2 bits.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // While in GRANT, last is the current owner.
  assign rel_norm = done[last] | ~req[last];
  assign rel_lim  = (HOLD_LIM != 8'd0) && (hold_cnt == HOLD_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      sel      <= 2'b00;
      last     <= 2'd3;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant    <= 4'b0001 << winner;
            sel      <= {winner[0], winner[1]};
            last     <= winner;
            hold_cnt <= 8'd1;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (rel_norm || rel_lim) begin
            grant   <= '0;
            timeout <= rel_lim & ~rel_norm;
            state   <= ST_TURN;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_TURN: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Bench for rr_bus_arbiter4. It runs three instances (MAX_HOLD 4, 8 and 0) on shared stimulus.
// It checks them against a vector table, hand-written sequences and a per-instance reference model.
module tb_rr_bus_arbiter4;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] req, done;
  logic [2:0][3:0] grant_o;
  logic [2:0][1:0] sel_o;
  logic [2:0]      busy_o, to_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter4 #(.MAX_HOLD(4)) u_h4 (.clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant_o[0]), .sel(sel_o[0]), .busy(busy_o[0]), .timeout(to_o[0]));
  rr_bus_arbiter4 #(.MAX_HOLD(8)) u_h8 (.clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant_o[1]), .sel(sel_o[1]), .busy(busy_o[1]), .timeout(to_o[1]));
  rr_bus_arbiter4 #(.MAX_HOLD(0)) u_h0 (.clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant_o[2]), .sel(sel_o[2]), .busy(busy_o[2]), .timeout(to_o[2]));

  function automatic int mh(input int i);
    return (i == 0) ? 4 : (i == 1) ? 8 : 0;
  endfunction

  // Reference model: the owner is an integer (-1 means none), and arbitration is a modulo scan.
  int       m_owner[3], m_turn[3], m_last[3], m_held[3];
  logic     m_to[3];
  logic [1:0] m_sel[3];

  task automatic model_step(input int i);
    bit rel, lim, fnd;
    int k;
    if (reset) begin
      m_owner[i] = -1; m_turn[i] = 0; m_last[i] = 3; m_held[i] = 0;
      m_to[i] = 1'b0; m_sel[i] = 2'b00;
    end else begin
      m_to[i] = 1'b0;
      if (m_owner[i] >= 0) begin
        rel = done[m_owner[i]] || !req[m_owner[i]];
        lim = (mh(i) != 0) && (m_held[i] == mh(i));
        if (rel || lim) begin
          m_to[i] = lim && !rel;
          m_owner[i] = -1;
          m_turn[i] = 1;
        end else m_held[i]++;
      end else if (m_turn[i] != 0) begin
        m_turn[i] = 0;
      end else begin
        fnd = 1'b0;
        for (int d = 1; d <= 4; d++) begin
          k = (m_last[i] + d) % 4;
          if (!fnd && req[k]) begin
            fnd = 1'b1;
            m_owner[i] = k; m_last[i] = k; m_held[i] = 1;
            m_sel[i] = (k == 1) ? 2'b10 : (k == 2) ? 2'b01 : 2'(k);
          end
        end
      end
    end
  endtask

  task automatic check_model(input int i);
    logic [3:0] eg;
    eg = (m_owner[i] >= 0) ? 4'(1 << m_owner[i]) : 4'b0000;
    checks++;
    if (grant_o[i] !== eg || sel_o[i] !== m_sel[i] || busy_o[i] !== (eg != 0) || to_o[i] !== m_to[i]) begin
      failures++;
      $display("FAIL model_mh%0d t=%0t got grant=%b sel=%b busy=%b to=%b want grant=%b sel=%b busy=%b to=%b",
               mh(i), $time, grant_o[i], sel_o[i], busy_o[i], to_o[i], eg, m_sel[i], eg != 0, m_to[i]);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dn);
    reset = r; req = rq; done = dn;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) check_model(i);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic rst; logic [3:0] req; logic [3:0] done;
    logic [3:0] g; logic [1:0] sel; logic to;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                     input logic [3:0] g, input logic [1:0] s, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.done = dn; v.g = g; v.sel = s; v.to = t;
    tbl.push_back(v);
  endtask

  initial begin
    int bad;
    logic [3:0] rq, dn;
    reset = 1'b1; req = '0; done = '0;

    // Vectors checked on the MAX_HOLD=4 instance.
    add(1, 4'h0, 4'h0, 4'b0000, 2'b00, 0);
    // Full rotation with done strobes.
    add(0, 4'hF, 4'h0, 4'b0001, 2'b00, 0);
    add(0, 4'hF, 4'h1, 4'b0000, 2'b00, 0);
    add(0, 4'hF, 4'h0, 4'b0000, 2'b00, 0);
    add(0, 4'hF, 4'h0, 4'b0010, 2'b10, 0);
    add(0, 4'hF, 4'h2, 4'b0000, 2'b10, 0);
    add(0, 4'hF, 4'h0, 4'b0000, 2'b10, 0);
    add(0, 4'hF, 4'h0, 4'b0100, 2'b01, 0);
    add(0, 4'hF, 4'h4, 4'b0000, 2'b01, 0);
    add(0, 4'hF, 4'h0, 4'b0000, 2'b01, 0);
    add(0, 4'hF, 4'h0, 4'b1000, 2'b11, 0);
    add(0, 4'hF, 4'h8, 4'b0000, 2'b11, 0);
    add(0, 4'hF, 4'h0, 4'b0000, 2'b11, 0);
    add(0, 4'hF, 4'h0, 4'b0001, 2'b00, 0);
    add(0, 4'hF, 4'h1, 4'b0000, 2'b00, 0);
    add(0, 4'h0, 4'h0, 4'b0000, 2'b00, 0);
    add(0, 4'h0, 4'h0, 4'b0000, 2'b00, 0);
    // Single requester 2, then it drops its request.
    add(0, 4'h4, 4'h0, 4'b0100, 2'b01, 0);
    add(0, 4'h4, 4'h0, 4'b0100, 2'b01, 0);
    add(0, 4'h0, 4'h0, 4'b0000, 2'b01, 0);
    add(0, 4'h0, 4'h0, 4'b0000, 2'b01, 0);
    // Hold limit of 4 on owner 1, then owner 3 after the turnaround.
    add(1, 4'h0, 4'h0, 4'b0000, 2'b00, 0);
    add(0, 4'hA, 4'h0, 4'b0010, 2'b10, 0);
    add(0, 4'hA, 4'h0, 4'b0010, 2'b10, 0);
    add(0, 4'hA, 4'h0, 4'b0010, 2'b10, 0);
    add(0, 4'hA, 4'h0, 4'b0010, 2'b10, 0);
    add(0, 4'hA, 4'h0, 4'b0000, 2'b10, 1);
    add(0, 4'hA, 4'h0, 4'b0000, 2'b10, 0);
    add(0, 4'hA, 4'h0, 4'b1000, 2'b11, 0);
    add(0, 4'hA, 4'h0, 4'b1000, 2'b11, 0);
    add(0, 4'hA, 4'h8, 4'b0000, 2'b11, 0);
    add(0, 4'h0, 4'h0, 4'b0000, 2'b11, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].rst, tbl[n].req, tbl[n].done);
      chk($sformatf("vec%0d", n), {1'b0, to_o[0], busy_o[0], sel_o[0], grant_o[0][2:0]} | {grant_o[0][3], 7'b0},
          {1'b0, tbl[n].to, tbl[n].g != 0, tbl[n].sel, tbl[n].g[2:0]} | {tbl[n].g[3], 7'b0});
    end

    // A done from a non-owner is ignored; the owner's done at the hold limit is a normal release.
    step(1, 4'h0, 4'h0);
    step(0, 4'h4, 4'h0);
    chk("own2_grant", {4'h0, grant_o[0]}, 8'h04);
    step(0, 4'h4, 4'h1);
    chk("done0_ignored", {4'h0, grant_o[0]}, 8'h04);
    step(0, 4'h4, 4'h1);
    step(0, 4'h4, 4'h0);
    chk("own2_still", {4'h0, grant_o[0]}, 8'h04);
    step(0, 4'h4, 4'h4);
    chk("done_at_limit", {3'b0, to_o[0], grant_o[0]}, 8'h00);

    // A reset in the middle of a grant to requester 3
    step(1, 4'h0, 4'h0);
    step(0, 4'h8, 4'h0);
    chk("own3_grant", {2'b0, sel_o[1], grant_o[1]}, 8'h38);
    step(1, 4'h8, 4'h0);
    chk("mid_reset", {busy_o[1], to_o[1], sel_o[1], grant_o[1]}, 8'h00);
    step(0, 4'h9, 4'h0);
    chk("post_reset_req0", {2'b0, sel_o[1], grant_o[1]}, 8'h01);

    // With MAX_HOLD=0, the grant is never revoked.
    step(1, 4'h0, 4'h0);
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      step(0, 4'h1, 4'h0);
      if (grant_o[2] !== 4'b0001 || to_o[2] !== 1'b0) bad++;
    end
    chk("nolimit_300", 8'(bad), 8'h00);

    // Randomized traffic: each request bit is sticky, done strobes are sparse, and resets are rare.
    step(1, 4'h0, 4'h0);
    rq = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      dn = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step($urandom_range(0, 149) == 0, rq, dn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
